// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: opcode constants, status codes, fetch states
// and the length/validity rules of the instruction set.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_REGS,
        S_CONST,
        S_DONE
    } fetch_state_e;

    // Length in bytes; unknown icodes report 1 since only byte 0 is ever read.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
            I_JXX, I_CALL:                    len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
            default:                          len = 4'd1;
        endcase
        return len;
    endfunction

    function automatic logic instr_valid(input logic [3:0] icode, input logic [3:0] ifun);
        logic ok;
        case (icode)
            I_RRMOVQ, I_JXX: ok = (ifun <= 4'd6);
            I_OPQ:           ok = (ifun <= 4'd3);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ:
                             ok = (ifun == 4'd0);
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/y86_instr_classify.sv
// Combinational decode of instruction byte 0 into the shape of the rest of the
// instruction: which optional fields follow, total length, and exception class.
module y86_instr_classify
    import y86_pkg::*;
(
    input  logic [7:0] byte0,
    output logic       need_regs,
    output logic       need_valC,
    output logic [3:0] len,
    output logic       invalid,
    output logic       is_halt
);

    logic [3:0] icode;
    logic [3:0] ifun;

    assign icode = byte0[7:4];
    assign ifun  = byte0[3:0];

    always_comb begin
        need_regs = 1'b0;
        need_valC = 1'b0;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regs = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regs = 1'b1;
                need_valC = 1'b1;
            end
            I_JXX, I_CALL: need_valC = 1'b1;
            default: ;
        endcase
    end

    assign len     = instr_len(icode);
    assign invalid = !instr_valid(icode, ifun);
    assign is_halt = (icode == I_HALT) && !invalid;

endmodule

// File: rtl/y86_fetch_unit.sv
// Multi-cycle byte-serial instruction fetch: walks memory from pc over a
// req/ack handshake and assembles icode/ifun/rA/rB/valC/valP with a status.
module y86_fetch_unit
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [1:0]  stat
);

    fetch_state_e state_reg;
    logic [63:0]  pc_reg;
    logic [63:0]  addr_reg;
    logic         req_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [3:0]   icode_reg;
    logic [3:0]   ifun_reg;
    logic [3:0]   ra_reg;
    logic [3:0]   rb_reg;
    logic [63:0]  valc_reg;
    logic [63:0]  valp_reg;
    stat_e        stat_reg;
    logic [3:0]   len_reg;
    logic         need_valc_reg;
    logic [2:0]   cidx_reg;

    logic         cls_need_regs;
    logic         cls_need_valc;
    logic [3:0]   cls_len;
    logic         cls_invalid;
    logic         cls_is_halt;

    y86_instr_classify u_classify (
        .byte0     (mem_rdata),
        .need_regs (cls_need_regs),
        .need_valC (cls_need_valc),
        .len       (cls_len),
        .invalid   (cls_invalid),
        .is_halt   (cls_is_halt)
    );

    logic         fetching;
    logic         last_byte;
    logic         finish;
    stat_e        fin_stat;
    logic [63:0]  fin_valp;

    // Decide, for the byte acked this cycle, whether the fetch ends here and how.
    always_comb begin
        fetching  = (state_reg == S_BYTE0) || (state_reg == S_REGS) || (state_reg == S_CONST);
        last_byte = 1'b0;
        case (state_reg)
            S_BYTE0: last_byte = cls_invalid || (cls_len == 4'd1);
            S_REGS:  last_byte = !need_valc_reg;
            S_CONST: last_byte = (cidx_reg == 3'd7);
            default: last_byte = 1'b0;
        endcase
        finish = fetching && mem_ack && (mem_err || last_byte);

        fin_stat = STAT_AOK;
        fin_valp = pc_reg + {60'd0, len_reg};
        if (mem_err) begin
            fin_stat = STAT_ADR;
            fin_valp = pc_reg;
        end else if (state_reg == S_BYTE0) begin
            fin_valp = pc_reg + 64'd1;
            if (cls_invalid)
                fin_stat = STAT_INS;
            else if (cls_is_halt)
                fin_stat = STAT_HLT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pc_reg        <= 64'd0;
            addr_reg      <= 64'd0;
            req_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            icode_reg     <= 4'd0;
            ifun_reg      <= 4'd0;
            ra_reg        <= R_NONE;
            rb_reg        <= R_NONE;
            valc_reg      <= 64'd0;
            valp_reg      <= 64'd0;
            stat_reg      <= STAT_AOK;
            len_reg       <= 4'd0;
            need_valc_reg <= 1'b0;
            cidx_reg      <= 3'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_BYTE0;
                        pc_reg    <= pc;
                        addr_reg  <= pc;
                        req_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                        icode_reg <= 4'd0;
                        ifun_reg  <= 4'd0;
                        ra_reg    <= R_NONE;
                        rb_reg    <= R_NONE;
                        valc_reg  <= 64'd0;
                        cidx_reg  <= 3'd0;
                    end
                end
                S_BYTE0, S_REGS, S_CONST: begin
                    if (mem_ack) begin
                        addr_reg <= addr_reg + 64'd1;
                        if (!mem_err) begin
                            case (state_reg)
                                S_BYTE0: begin
                                    icode_reg     <= mem_rdata[7:4];
                                    ifun_reg      <= mem_rdata[3:0];
                                    len_reg       <= cls_len;
                                    need_valc_reg <= cls_need_valc;
                                    if (!last_byte)
                                        state_reg <= cls_need_regs ? S_REGS : S_CONST;
                                end
                                S_REGS: begin
                                    ra_reg <= mem_rdata[7:4];
                                    rb_reg <= mem_rdata[3:0];
                                    if (!last_byte)
                                        state_reg <= S_CONST;
                                end
                                default: begin
                                    valc_reg[{cidx_reg, 3'b000} +: 8] <= mem_rdata;
                                    cidx_reg <= cidx_reg + 3'd1;
                                end
                            endcase
                        end
                        if (finish) begin
                            state_reg <= S_DONE;
                            req_reg   <= 1'b0;
                            done_reg  <= 1'b1;
                            stat_reg  <= fin_stat;
                            valp_reg  <= fin_valp;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign mem_req  = req_reg;
    assign mem_addr = addr_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign icode    = icode_reg;
    assign ifun     = ifun_reg;
    assign rA       = ra_reg;
    assign rB       = rb_reg;
    assign valC     = valc_reg;
    assign valP     = valp_reg;
    assign stat     = stat_reg;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Randomized bench for y86_fetch_unit against an instruction-level model of
// the Y86-64 fetch rules, plus directed cases for wrap, faults and reset.
module tb_y86_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic        busy;
    logic        done;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [1:0]  stat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prog [16];

    y86_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .busy      (busy),
        .done      (done),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .valP      (valP),
        .stat      (stat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [1:0]  stat;
        int          n;
    } exp_t;

    // Whole-instruction view: how many bytes the instruction has, which were
    // delivered before any fault, and what that makes each field.
    function automatic exp_t model(input logic [63:0] p, input int err_at);
        exp_t       e;
        int         len, coff, n_ok;
        bit         ok, regs, cst;
        logic [3:0] ic, fn;
        ic = prog[0][7:4];
        fn = prog[0][3:0];
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        ok = (ic <= 4'hB);
        if (ic == 4'h2 || ic == 4'h7) ok = ok && (fn <= 4'd6);
        else if (ic == 4'h6)          ok = ok && (fn <= 4'd3);
        else                          ok = ok && (fn == 4'd0);
        regs = (len == 2) || (len == 10);
        cst  = (len >= 9);
        coff = regs ? 2 : 1;
        e.n    = ok ? len : 1;
        e.stat = !ok ? 2'd3 : (ic == 4'h0) ? 2'd1 : 2'd0;
        e.valp = p + 64'(e.n);
        n_ok   = e.n;
        if (err_at >= 0 && err_at < e.n) begin
            e.n    = err_at + 1;
            n_ok   = err_at;
            e.stat = 2'd2;
            e.valp = p;
        end
        e.icode = (n_ok >= 1) ? ic : 4'h0;
        e.ifun  = (n_ok >= 1) ? fn : 4'h0;
        e.ra    = (ok && regs && n_ok >= 2) ? prog[1][7:4] : 4'hF;
        e.rb    = (ok && regs && n_ok >= 2) ? prog[1][3:0] : 4'hF;
        e.valc  = 64'd0;
        for (int k = 0; k < 8; k++)
            if (ok && cst && coff + k < n_ok)
                e.valc[8*k +: 8] = prog[coff + k];
        return e;
    endfunction

    task automatic run_fetch(input logic [63:0] pc_in, input int waits, input int err_at, input bit poke);
        exp_t e;
        int   cyc, nreads, wcnt, addr_bad, req_gap, done_cyc;
        e = model(pc_in, err_at);
        @(negedge clk);
        start = 1'b1;
        pc    = pc_in;
        @(negedge clk);
        start = 1'b0;
        pc    = 64'd0;
        cyc = 1; nreads = 0; wcnt = 0; addr_bad = 0; req_gap = 0; done_cyc = -1;
        while (cyc < 400) begin
            mem_ack   = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = 8'($urandom);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!mem_req) begin
                req_gap++;
            end else begin
                if (mem_addr !== pc_in + 64'(nreads)) addr_bad++;
                if (wcnt < waits) begin
                    wcnt++;
                end else begin
                    wcnt      = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = prog[nreads & 15];
                    mem_err   = (nreads == err_at);
                    nreads++;
                end
            end
            if (poke && busy && cyc == 4) begin
                start = 1'b1;
                pc    = {$urandom, $urandom};
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        mem_ack = 1'b0;
        mem_err = 1'b0;
        $display("tx pc=%h byte0=%h waits=%0d err_at=%0d -> stat=%0d valP=%h valC=%h done_cyc=%0d",
                 pc_in, prog[0], waits, err_at, stat, valP, valC, done_cyc);
        check("done_cycle", 64'(done_cyc), 64'(e.n * (waits + 1) + 1));
        check("num_reads",  64'(nreads), 64'(e.n));
        check("addr_seq",   64'(addr_bad), 64'd0);
        check("req_gaps",   64'(req_gap), 64'd0);
        check("icode",      64'(icode), 64'(e.icode));
        check("ifun",       64'(ifun),  64'(e.ifun));
        check("rA",         64'(rA),    64'(e.ra));
        check("rB",         64'(rB),    64'(e.rb));
        check("valC",       valC,       e.valc);
        check("valP",       valP,       e.valp);
        check("stat",       64'(stat),  64'(e.stat));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("busy_idle",  64'(busy), 64'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   64'(mem_req), 64'd0);
        check({tag, "_addr"},  mem_addr,     64'd0);
        check({tag, "_busy"},  64'(busy),    64'd0);
        check({tag, "_done"},  64'(done),    64'd0);
        check({tag, "_icode"}, 64'(icode),   64'd0);
        check({tag, "_rA"},    64'(rA),      64'hF);
        check({tag, "_rB"},    64'(rB),      64'hF);
        check({tag, "_valC"},  valC,         64'd0);
        check({tag, "_valP"},  valP,         64'd0);
        check({tag, "_stat"},  64'(stat),    64'd0);
    endtask

    initial begin
        logic [3:0] ic, fn;
        rst = 1'b1; start = 1'b0; pc = 64'd0;
        mem_ack = 1'b0; mem_rdata = 8'd0; mem_err = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // irmovq at 0x100, zero wait states
        fill_random();
        prog[0] = 8'h30; prog[1] = 8'hF3;
        for (int k = 0; k < 8; k++) prog[2 + k] = 8'(8 - k);
        run_fetch(64'h100, 0, -1, 1'b0);
        check("irmovq_valC", valC, 64'h0102030405060708);
        check("irmovq_valP", valP, 64'h10A);

        // call at 0x20 with two wait cycles per byte, start poked while busy
        fill_random();
        prog[0] = 8'h80;
        run_fetch(64'h20, 2, -1, 1'b1);

        fill_random(); prog[0] = 8'hC0; run_fetch(64'h1234, 0, -1, 1'b0);
        fill_random(); prog[0] = 8'h63; run_fetch(64'h300, 1, -1, 1'b0);
        fill_random(); prog[0] = 8'h64; run_fetch(64'h308, 0, -1, 1'b0);

        // rmmovq across the top of the address space, then with a fault on byte 2
        fill_random(); prog[0] = 8'h40; prog[1] = 8'h12;
        run_fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, -1, 1'b0);
        check("wrap_valP", valP, 64'h6);
        run_fetch(64'hFFFF_FFFF_FFFF_FFFC, 1, 2, 1'b0);

        // reset in the middle of mrmovq
        fill_random(); prog[0] = 8'h50;
        @(negedge clk);
        start = 1'b1; pc = 64'h200;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1; mem_rdata = prog[i];
            @(negedge clk);
        end
        check("pre_rst_req", 64'(mem_req), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req",  64'(mem_req), 64'd0);
        check("post_rst_busy", 64'(busy),    64'd0);
        mem_ack = 1'b0;
        fill_random(); prog[0] = 8'h10;
        run_fetch(64'h40, 0, -1, 1'b0);

        fill_random(); prog[0] = 8'h00;
        run_fetch(64'h0, 0, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            fill_random();
            ic = 4'($urandom_range(0, 12));
            if (ic == 4'h2 || ic == 4'h6 || ic == 4'h7)
                fn = 4'($urandom_range(0, 7));
            else
                fn = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            prog[0] = {ic, fn};
            run_fetch(($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                                   : {$urandom, $urandom},
                      int'($urandom_range(0, 2)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
                      1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
